// File: rtl/sd_loader_pkg.sv
// sd_loader_pkg: shared types and constants for the SD boot loader.
package sd_loader_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_INIT, S_ISSUE, S_WAIT_R1, S_DATA, S_CRC, S_NEXT, S_DONE, S_ERROR
  } state_t;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [1:0] START_BITS = 2'b01;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_R1 = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CRC = 2'd3;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam int WORDS_PER_SECTOR = 128;
  function automatic logic [47:0] cmd17_frame(input logic [31:0] arg);
    return {START_BITS, CMD17, arg, 7'h00, 1'b1};
  endfunction
endpackage

// File: rtl/sd_crc16_word.sv
// sd_crc16_word: one-step CRC16-CCITT update over a 32-bit word, MSB first.
module sd_crc16_word
  import sd_loader_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] word_in,
  output logic [15:0] crc_out
);
  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = 31; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ word_in[i]) ? CRC_POLY : 16'h0000);
    crc_out = c;
  end
endmodule

// File: rtl/sd_boot_loader.sv
// sd_boot_loader: CMD17 sector loader copying SD blocks into boot memory.
// Define LDR_CRC16_CHECK_EN to verify each block's CRC16 against the card.
module sd_boot_loader
  import sd_loader_pkg::*;
#(
  parameter logic [31:0] START_SECTOR = 32'd0,
  parameter int          NUM_SECTORS  = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
  input  logic        ldr_clk_i,
  input  logic        ldr_rst_n_i,
  input  logic        ldr_start_i,
  input  logic        spi_initdone_i,
  input  logic [2:0]  spi_flagreg_i,
  input  logic [31:0] spi_data_i,
  output logic [47:0] spi_cmd_o,
  output logic        spi_enableoper_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        ldr_busy_o,
  output logic        ldr_done_o,
  output logic        ldr_error_o,
  output logic [1:0]  ldr_errcode_o
);
  localparam logic [6:0] LAST_WORD = 7'(WORDS_PER_SECTOR - 1);
  state_t      state_q, state_d;
  logic [15:0] sec_q, sec_d, tmo_q, tmo_d;
  logic [6:0]  word_q, word_d;
  logic [47:0] cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]  errcode_q, errcode_d;
  logic        en_q, en_d, we_q, we_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        crc_ok, waiting, acc, tmo_hit;
`ifdef LDR_CRC16_CHECK_EN
  logic [15:0] crc_q, crc_d, crc_nxt;
  sd_crc16_word u_crc (.crc_in(crc_q), .word_in(spi_data_i), .crc_out(crc_nxt));
  assign crc_ok = spi_data_i[15:0] == crc_q;
  always_comb crc_d = (state_q == S_ISSUE) ? 16'h0000 :
                      (state_q == S_DATA && spi_flagreg_i[0]) ? crc_nxt : crc_q;
  always_ff @(posedge ldr_clk_i or negedge ldr_rst_n_i)
    if (!ldr_rst_n_i) crc_q <= '0;
    else crc_q <= crc_d;
`else
  assign crc_ok = 1'b1;
`endif
  assign waiting = state_q inside {S_WAIT_R1, S_DATA, S_CRC};
  assign acc = (state_q == S_WAIT_R1) ? spi_flagreg_i[1] : waiting && spi_flagreg_i[0];
  assign tmo_hit = tmo_q == TIMEOUT - 16'd1;
  always_comb begin
    state_d = state_q;
    sec_d = sec_q;
    word_d = word_q;
    errcode_d = errcode_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR:
        if (ldr_start_i) begin
          state_d = S_WAIT_INIT;
          sec_d = '0;
          word_d = '0;
          errcode_d = ERR_NONE;
        end
      S_WAIT_INIT: state_d = (spi_initdone_i && !spi_flagreg_i[2]) ? S_ISSUE : S_WAIT_INIT;
      S_ISSUE: state_d = S_WAIT_R1;
      S_WAIT_R1:
        if (spi_flagreg_i[1]) begin
          state_d = (spi_data_i[7:0] == 8'h00) ? S_DATA : S_ERROR;
          errcode_d = (spi_data_i[7:0] == 8'h00) ? errcode_q : ERR_R1;
        end
      S_DATA:
        if (spi_flagreg_i[0]) begin
          we_d = 1'b1;
          addr_d = BASE_ADDR + {7'h00, sec_q, word_q, 2'b00};
          wdata_d = spi_data_i;
          word_d = word_q + 7'd1;
          state_d = (word_q == LAST_WORD) ? S_CRC : S_DATA;
        end
      S_CRC:
        if (spi_flagreg_i[0]) begin
          state_d = crc_ok ? S_NEXT : S_ERROR;
          errcode_d = crc_ok ? errcode_q : ERR_CRC;
        end
      S_NEXT: begin
        sec_d = sec_q + 16'd1;
        state_d = (32'(sec_q) + 32'd1 == 32'(NUM_SECTORS)) ? S_DONE : S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
    if (waiting && !acc && tmo_hit) begin
      state_d = S_ERROR;
      errcode_d = ERR_TIMEOUT;
    end
    // outputs are registered from the next state so they line up with it
    en_d = state_d == S_ISSUE;
    cmd_d = en_d ? cmd17_frame(START_SECTOR + 32'(sec_d)) : cmd_q;
    busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    done_d = state_d == S_DONE;
    error_d = state_d == S_ERROR;
    tmo_d = (state_d != state_q || acc) ? 16'h0000 : tmo_q + 16'd1;
  end
  always_ff @(posedge ldr_clk_i or negedge ldr_rst_n_i)
    if (!ldr_rst_n_i) begin
      state_q <= S_IDLE;
      sec_q <= '0;
      word_q <= '0;
      tmo_q <= '0;
      cmd_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      errcode_q <= '0;
      en_q <= 1'b0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q <= sec_d;
      word_q <= word_d;
      tmo_q <= tmo_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      errcode_q <= errcode_d;
      en_q <= en_d;
      we_q <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  assign spi_cmd_o = cmd_q;
  assign spi_enableoper_o = en_q;
  assign mem_we_o = we_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign ldr_busy_o = busy_q;
  assign ldr_done_o = done_q;
  assign ldr_error_o = error_q;
  assign ldr_errcode_o = errcode_q;
endmodule

// File: doc/sd_boot_loader.md
# sd_boot_loader

Boot-time sector loader sitting directly upstream of the SPI microSDHC controller. After the controller reports initialisation done, it issues CMD17 (READ_SINGLE_BLOCK) frames for a contiguous run of sectors, consumes the 32-bit data words the controller returns, and writes them into on-chip boot memory at incrementing addresses. It reports done or a coded error to the boot sequencer.

## Interface
- START_SECTOR, 32'd0, first SDHC block address read.
- NUM_SECTORS, 8, sectors loaded, 1..65535.
- BASE_ADDR, 32'h0000_0000, byte address of the first memory word.
- TIMEOUT, 16'hFFFF, idle cycles allowed while waiting for a controller flag.
- ldr_clk_i  in  1  single clock, same domain as the SPI controller.
- ldr_rst_n_i  in  1  reset, asynchronous and active-low.
- ldr_start_i  in  1  start request, sampled high for one cycle.
- spi_initdone_i  in  1  controller card-init complete (level).
- spi_flagreg_i  in  3  [0] data word valid pulse, [1] R1 byte valid pulse, [2] controller busy.
- spi_data_i  in  32  data word, or R1 in [7:0] when flag[1].
- spi_cmd_o  out  48  command frame to controller.
- spi_enableoper_o  out  1  one-cycle pulse: launch spi_cmd_o.
- mem_we_o  out  1  one-cycle write strobe; memory always accepts.
- mem_addr_o  out  32  byte address, word aligned.
- mem_wdata_o  out  32  write data.
- ldr_busy_o, ldr_done_o, ldr_error_o  out  1 each  status levels.
- ldr_errcode_o  out  2  0 none, 1 R1 nonzero, 2 timeout, 3 CRC mismatch.

## Operation
- States: IDLE, WAIT_INIT, ISSUE, WAIT_R1, DATA, CRC, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR: ldr_start_i -> WAIT_INIT; clears done/error/errcode, sector index, word index. Start in any other state ignored.
- WAIT_INIT: stay until spi_initdone_i high and flag[2] low, then ISSUE. No timeout here.
- ISSUE: spi_cmd_o = {2'b01, 6'd17, START_SECTOR + sector_idx, 7'h00, 1'b1}; spi_enableoper_o high one cycle; -> WAIT_R1.
- WAIT_R1: on flag[1]: R1 == 8'h00 -> DATA, else ERROR code 1. flag[0] ignored here; flag[1] has priority if both.
- DATA: each flag[0] writes one word; after word 127 -> CRC. flag[1] ignored.
- CRC: next flag[0] carries card CRC16 in [15:0]; compare (see Configuration); -> NEXT or ERROR code 3.
- NEXT: sector_idx+1; if equals NUM_SECTORS -> DONE else ISSUE.
- Timeout counter reloads on state entry and on every accepted flag in WAIT_R1, DATA, CRC; reaching TIMEOUT -> ERROR code 2.
- Byte order: first card byte is spi_data_i[31:24]; word written unchanged.
- Address = BASE_ADDR + 4*(sector_idx*128 + word_idx), 32-bit modulo 2^32 (wraps silently).
- sector_idx 16 bits, word_idx 7 bits, timeout counter 16 bits.

## Timing
- Reset values: all outputs 0, spi_cmd_o 48'h0, state IDLE.
- Data word flag in cycle N -> mem_we_o, mem_addr_o, mem_wdata_o registered, valid cycle N+1, strobe one cycle.
- ISSUE lasts exactly one cycle; WAIT_R1 entered the cycle after the launch pulse.
- Back-to-back flag[0] every cycle supported, one write per cycle.
- ldr_busy_o high in every state except IDLE, DONE, ERROR; done/error asserted the cycle the state is entered and held until next start.
- Reset mid-operation: immediate return to IDLE, no further writes or launches; partial memory contents are not cleaned.

## Configuration
- LDR_CRC16_CHECK_EN defined: CRC16-CCITT (poly 0x1021, init 0x0000) accumulated over the 512 data bytes, 4 bytes per word MSB first; mismatch with card CRC -> ERROR code 3.
- Undefined: CRC word consumed and discarded; CRC always passes; errcode 3 never produced.

## Structure
- Package sd_loader_pkg: state enum, CMD17 index, start bits, error-code constants, CRC polynomial, WORDS_PER_SECTOR = 128.
- One sub-module sd_crc16_word: combinational 32-bit parallel CRC16 update (crc_in, word_in -> crc_out), instantiated only under LDR_CRC16_CHECK_EN.

## Test plan
- NUM_SECTORS=2, START_SECTOR=100, R1=0, 129 words each -> two launches with arguments 100 and 101, 256 writes, addresses BASE_ADDR..BASE_ADDR+0x3FC, done=1, errcode 0.
- R1=8'h05 on first command -> ERROR, errcode 1, zero mem_we_o pulses.
- Controller stops after 40 words, TIMEOUT=16'd50 -> ERROR, errcode 2 exactly 50 cycles after last word, 40 writes.
- With LDR_CRC16_CHECK_EN, all-zero block with CRC 16'h0000 -> done; CRC 16'h1234 -> errcode 3. Without macro both -> done.
- ldr_rst_n_i low during word 60 of sector 0 -> all outputs 0 asynchronously, IDLE; subsequent start reloads from START_SECTOR.
- BASE_ADDR=32'hFFFF_FF00, NUM_SECTORS=1 -> addresses wrap past 32'hFFFF_FFFC to 32'h0000_0000; ldr_start_i pulsed while busy has no effect.
